// File: rtl/branch_predictor.sv
// branch_predictor: gshare front-end predictor with in-flight branch tracking.
// The PHT index is the fetch PC low bits XOR the global history register (GHR).
// Each entry holds a 2-bit saturating counter. In-order commit feedback trains
// the counters. A mispredict rebuilds the GHR from the history that was saved
// with the oldest in-flight branch.
// Optional feature: define BP_STATS_EN to add the saturating stat_commits /
// stat_failures outputs.
module branch_predictor #(
  parameter int PAT_W  = 10,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              prediction,
  output logic [PAT_W-1:0]  pattern_out,
  input  logic              commit_valid,
  input  logic              commit_failure,
  input  logic [PAT_W-1:0]  commit_pattern
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_commits,
  output logic [31:0]       stat_failures
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PHT_N = 1 << PAT_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PAT_W-1:0] init_idx_q;
  logic [PAT_W-1:0] ghr_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [1:0]       pht [PHT_N];
  logic             fifo_pred_q [DEPTH];
  logic [PAT_W-1:0] fifo_ghr_q  [DEPTH];

  logic             in_run;
  logic [PAT_W-1:0] pattern_idx;
  logic             commit_fire;
  logic             mispredict;
  logic             fetch_fire;
  logic             head_pred;
  logic [PAT_W-1:0] head_ghr;
  logic             actual;

  logic             pht_we;
  logic [PAT_W-1:0] pht_waddr;
  logic [1:0]       pht_wdata;
  logic [1:0]       pht_old;

  // Only the low PAT_W bits of the PC feed the hash; the rest are deliberately dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fetch_pc[ADDR_W-1:PAT_W];

  // Wrap-around pointer increment for the in-flight FIFO.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Front-end lookup: the hash and counter read are combinational, and they are forced to zero while the table initialises.
  always_comb begin
    in_run      = (state_q == RUN);
    pattern_idx = fetch_pc[PAT_W-1:0] ^ ghr_q;
    pattern_out = in_run ? pattern_idx : '0;
    prediction  = in_run ? pht[pattern_idx][1] : 1'b0;
    fetch_ready = in_run && ((count_q < DEPTH_CNT) || commit_valid);
  end

  // Commit/fetch qualification and the oldest branch's recorded outcome and history.
  always_comb begin
    commit_fire = in_run && commit_valid;
    mispredict  = commit_fire && commit_failure;
    fetch_fire  = fetch_valid && fetch_ready && !(commit_valid && commit_failure);
    head_pred   = fifo_pred_q[head_q];
    head_ghr    = fifo_ghr_q[head_q];
    actual      = head_pred ^ commit_failure;
  end

  // Next-state logic: the table is swept once, and the predictor then runs until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_idx_q == '1) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Initialisation sweep index, one PHT entry per cycle.
  always_ff @(posedge clk) begin
    if (reset)                 init_idx_q <= '0;
    else if (state_q == INIT)  init_idx_q <= init_idx_q + PAT_W'(1);
  end

  // PHT write port: the init sweep writes weakly not-taken, and commits apply saturating training.
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = '0;
    pht_wdata = 2'b01;
    pht_old   = pht[commit_pattern];
    if (state_q == INIT) begin
      pht_we    = 1'b1;
      pht_waddr = init_idx_q;
      pht_wdata = 2'b01;
    end else if (commit_fire) begin
      pht_we    = 1'b1;
      pht_waddr = commit_pattern;
      if (actual) pht_wdata = (pht_old == 2'b11) ? 2'b11 : pht_old + 2'b01;
      else        pht_wdata = (pht_old == 2'b00) ? 2'b00 : pht_old - 2'b01;
    end
  end

  // Counter storage; the write lands at the edge, so a same-cycle fetch sees the old value.
  always_ff @(posedge clk) begin
    if (!reset && pht_we) pht[pht_waddr] <= pht_wdata;
  end

  // Speculative history and FIFO bookkeeping. A mispredict rebuilds history and flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (mispredict) begin
      ghr_q   <= {head_ghr[PAT_W-2:0], actual};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (fetch_fire) begin
        ghr_q  <= {ghr_q[PAT_W-2:0], prediction};
        tail_q <= ptr_inc(tail_q);
      end
      if (commit_fire) head_q <= ptr_inc(head_q);
      case ({fetch_fire, commit_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO payload: the prediction and the pre-shift history recorded for each accepted branch.
  always_ff @(posedge clk) begin
    if (!reset && fetch_fire) begin
      fifo_pred_q[tail_q] <= prediction;
      fifo_ghr_q[tail_q]  <= ghr_q;
    end
  end

  // A commit with nothing in flight means the branch unit and the predictor are out of step.
  assert property (@(posedge clk) disable iff (reset) (commit_fire |-> (count_q != '0)));

`ifdef BP_STATS_EN
  // Registered saturating commit and failure statistics, counted only while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_commits  <= '0;
      stat_failures <= '0;
    end else if (commit_fire) begin
      if (stat_commits != '1) stat_commits <= stat_commits + 32'd1;
      if (commit_failure && (stat_failures != '1)) stat_failures <= stat_failures + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus randomized traffic, checked
// against a queue-based gshare reference model (PAT_W=4, DEPTH=4).
module tb_branch_predictor;

  localparam int PAT_W  = 4;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;
  localparam int PHT_N  = 1 << PAT_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_valid = 1'b0;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_pc = '0;
  logic              prediction;
  logic [PAT_W-1:0]  pattern_out;
  logic              commit_valid = 1'b0;
  logic              commit_failure = 1'b0;
  logic [PAT_W-1:0]  commit_pattern = '0;
`ifdef BP_STATS_EN
  logic [31:0]       stat_commits;
  logic [31:0]       stat_failures;
`endif

  branch_predictor #(.PAT_W(PAT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .prediction     (prediction),
    .pattern_out    (pattern_out),
    .commit_valid   (commit_valid),
    .commit_failure (commit_failure),
    .commit_pattern (commit_pattern)
`ifdef BP_STATS_EN
    ,
    .stat_commits   (stat_commits),
    .stat_failures  (stat_failures)
`endif
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit fv;
    int pc;
    bit cv;
    bit cf;
    int cp;
    bit exp_ready;
    bit exp_pred;
    int exp_pat;
  } vec_t;

  typedef struct {
    int pred;
    int ghr;
  } entry_t;

  int     m_pht [PHT_N];
  int     m_ghr;
  entry_t m_fifo [$];
  bit     m_run;
  int     m_init_cycles;
  int     m_commits;
  int     m_failures;

  int checks   = 0;
  int failures = 0;

  vec_t tab [$];

  function automatic vec_t mk(bit fv, int pc, bit cv, bit cf, int cp, bit r, bit p, int pat);
    vec_t v;
    v.rst = 1'b0; v.fv = fv; v.pc = pc; v.cv = cv; v.cf = cf; v.cp = cp;
    v.exp_ready = r; v.exp_pred = p; v.exp_pat = pat;
    return v;
  endfunction

  function automatic void modelOutputs(input vec_t v, output bit e_ready, output bit e_pred, output int e_pat);
    if (!m_run) begin
      e_ready = 1'b0; e_pred = 1'b0; e_pat = 0;
    end else begin
      e_pat   = (v.pc % PHT_N) ^ m_ghr;
      e_pred  = (m_pht[e_pat] >= 2);
      e_ready = (m_fifo.size() < DEPTH) || v.cv;
    end
  endfunction

  function automatic void modelUpdate(input vec_t v);
    bit     r, p, fire, act;
    int     pat, old_ghr;
    entry_t e;
    if (v.rst) begin
      m_run = 1'b0; m_init_cycles = 0; m_ghr = 0; m_fifo.delete();
      m_commits = 0; m_failures = 0;
      return;
    end
    if (!m_run) begin
      m_init_cycles++;
      if (m_init_cycles == PHT_N) begin
        m_run = 1'b1;
        foreach (m_pht[i]) m_pht[i] = 1;
      end
      return;
    end
    modelOutputs(v, r, p, pat);
    old_ghr = m_ghr;
    fire = v.fv && r && !(v.cv && v.cf);
    if (v.cv && m_fifo.size() > 0) begin
      e   = m_fifo[0];
      act = (e.pred != 0) ^ v.cf;
      if (act) m_pht[v.cp] = (m_pht[v.cp] == 3) ? 3 : m_pht[v.cp] + 1;
      else     m_pht[v.cp] = (m_pht[v.cp] == 0) ? 0 : m_pht[v.cp] - 1;
      m_commits++;
      if (v.cf) begin
        m_failures++;
        m_ghr = ((e.ghr << 1) | int'(act)) % PHT_N;
        m_fifo.delete();
      end else begin
        void'(m_fifo.pop_front());
      end
    end
    if (fire) begin
      e.pred = int'(p); e.ghr = old_ghr;
      m_fifo.push_back(e);
      m_ghr = ((old_ghr << 1) | int'(p)) % PHT_N;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_tab, input bit do_chk, input string label);
    bit e_ready, e_pred;
    int e_pat;
    reset          = v.rst;
    fetch_valid    = v.fv;
    fetch_pc       = ADDR_W'(v.pc);
    commit_valid   = v.cv;
    commit_failure = v.cf;
    commit_pattern = PAT_W'(v.cp);
    @(negedge clk);
    modelOutputs(v, e_ready, e_pred, e_pat);
    if (do_chk) begin
      checkOutput({label, " ready"}, 32'(fetch_ready), 32'(e_ready));
      checkOutput({label, " pred"},  32'(prediction),  32'(e_pred));
      checkOutput({label, " pat"},   32'(pattern_out), e_pat);
`ifdef BP_STATS_EN
      checkOutput({label, " stat_commits"},  stat_commits,  m_commits);
      checkOutput({label, " stat_failures"}, stat_failures, m_failures);
`endif
    end
    if (use_tab) begin
      checkOutput({label, " tab_ready"}, 32'(fetch_ready), 32'(v.exp_ready));
      checkOutput({label, " tab_pred"},  32'(prediction),  32'(v.exp_pred));
      checkOutput({label, " tab_pat"},   32'(pattern_out), v.exp_pat);
    end
    @(posedge clk);
    modelUpdate(v);
    #1;
  endtask

  // Initialisation window: noise on every input, and the outputs must hold at zero for exactly PHT_N cycles.
  task automatic runInit(input string label);
    vec_t v;
    for (int i = 0; i < PHT_N; i++) begin
      v = mk(1'b1, 5, 1'b1, 1'b1, 5, 1'b0, 1'b0, 0);
      applyStimulus(v, 1'b1, 1'b1, $sformatf("%s_init[%0d]", label, i));
    end
  endtask

  initial begin
    vec_t v;

    // Directed table: history, training, full FIFO, dropped fetch, recovery, no bypass.
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0));
    tab.push_back(mk(1, 3, 0, 0, 0,  1, 0, 3));
    tab.push_back(mk(1, 3, 0, 0, 0,  1, 0, 3));
    tab.push_back(mk(0, 5, 1, 0, 5,  1, 0, 5));
    tab.push_back(mk(0, 5, 1, 0, 5,  1, 0, 5));
    tab.push_back(mk(0, 5, 1, 1, 5,  1, 0, 5));
    tab.push_back(mk(1, 4, 0, 0, 0,  1, 0, 5));
    tab.push_back(mk(0, 5, 1, 1, 5,  1, 0, 7));
    tab.push_back(mk(1, 6, 0, 0, 0,  1, 1, 5));
    tab.push_back(mk(1, 6, 0, 0, 0,  1, 0, 1));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 14));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 12));
    tab.push_back(mk(1, 0, 0, 0, 0,  0, 0, 8));
    tab.push_back(mk(1, 0, 1, 0, 5,  1, 0, 8));
    tab.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 9,  1, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 9,  1, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 9,  1, 0, 0));
    tab.push_back(mk(1, 0, 1, 1, 9,  1, 0, 0));
    tab.push_back(mk(1, 4, 0, 0, 0,  1, 1, 5));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 3));
    tab.push_back(mk(1, 3, 0, 0, 0,  1, 1, 5));
    tab.push_back(mk(0, 0, 1, 0, 5,  1, 0, 13));
    tab.push_back(mk(1, 0, 1, 0, 3,  1, 0, 13));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 10));
    tab.push_back(mk(1, 0, 1, 1, 5,  1, 0, 4));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 12));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 8));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0));
    tab.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0));
    tab.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0));
    tab.push_back(mk(1, 5, 1, 0, 5,  1, 1, 5));
    tab.push_back(mk(0, 4, 0, 0, 0,  0, 0, 5));
    tab.push_back(mk(0, 0, 1, 0, 15, 1, 0, 1));
    tab.push_back(mk(0, 0, 1, 0, 15, 1, 0, 1));

    m_run = 1'b0; m_init_cycles = 0; m_ghr = 0; m_commits = 0; m_failures = 0;
    foreach (m_pht[i]) m_pht[i] = 0;

    $display("[TB] reset and initial table sweep");
    v = mk(0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    applyStimulus(v, 1'b0, 1'b0, "reset0");
    runInit("first");

    $display("[TB] directed vector table");
    for (int i = 0; i < tab.size(); i++)
      applyStimulus(tab[i], 1'b1, 1'b1, $sformatf("tab[%0d]", i));

    $display("[TB] reset mid-run with two branches in flight");
    v = mk(1, 5, 1, 1, 5, 0, 0, 0);
    v.rst = 1'b1;
    applyStimulus(v, 1'b0, 1'b1, "reset1");
`ifdef BP_STATS_EN
    checkOutput("reset1 stat_commits_zero",  stat_commits,  32'd0);
    checkOutput("reset1 stat_failures_zero", stat_failures, 32'd0);
`endif
    runInit("second");
    applyStimulus(mk(1, 15, 0, 0, 0,  1, 0, 15), 1'b1, 1'b1, "post_reset0");
    applyStimulus(mk(0, 0,  1, 1, 15, 1, 0, 0),  1'b1, 1'b1, "post_reset1");
    applyStimulus(mk(1, 14, 0, 0, 0,  1, 1, 15), 1'b1, 1'b1, "post_reset2");

    $display("[TB] randomized traffic against the reference model");
    for (int i = 0; i < 1500; i++) begin
      v.rst = ($urandom_range(0, 299) == 0);
      v.fv  = ($urandom_range(0, 3) != 0);
      v.pc  = int'($urandom_range(0, (1 << ADDR_W) - 1));
      v.cv  = (m_run && (m_fifo.size() > 0)) ? ($urandom_range(0, 1) == 1) : 1'b0;
      v.cf  = ($urandom_range(0, 3) == 0);
      v.cp  = int'($urandom_range(0, PHT_N - 1));
      applyStimulus(v, 1'b0, 1'b1, $sformatf("rand[%0d]", i));
    end

    reset = 1'b0; fetch_valid = 1'b0; commit_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end gshare predictor. It produces the `prediction` bit and PHT index (`pattern`) that travel with each fetched branch into the branch unit.
- It consumes that unit's in-order commit feedback (`failure`, `pattern`) to train 2-bit counters and repair speculative global history.
- It tracks in-flight branches in a small FIFO so the actual outcome can be recovered as `prediction ^ failure`.

Parameters:
- PAT_W, 10, PHT index width and global history register (GHR) width; PHT has 2**PAT_W entries.
- ADDR_W, 14, instruction address width.
- DEPTH, 4, max in-flight (fetched, uncommitted) branches; must equal the branch unit's entry count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high; full reinitialisation
- fetch_valid  input  1  a conditional branch is being issued to the branch unit this cycle
- fetch_ready  output  1  predictor can accept a branch
- fetch_pc  input  ADDR_W  address of the fetched branch
- prediction  output  1  1 = predict taken; valid whenever fetch_ready
- pattern_out  output  PAT_W  PHT index used for `prediction`; forwarded with the branch
- commit_valid  input  1  oldest branch commits this cycle
- commit_failure  input  1  committed branch was mispredicted
- commit_pattern  input  PAT_W  PHT index returned with the committed branch

Behaviour:
- State machine, states INIT and RUN.
  - reset (any state, any cycle) -> INIT, init_idx=0, GHR=0, FIFO count=0.
  - INIT: each cycle write PHT[init_idx]=2'b01 (weakly not-taken) and increment init_idx.
  - INIT -> RUN after the cycle that writes index 2**PAT_W-1 (exactly 2**PAT_W cycles).
  - In INIT: fetch_ready=0, prediction=0, pattern_out=0; commit inputs are ignored.
- Index: pattern_out = fetch_pc[PAT_W-1:0] ^ GHR. This path is combinational.
- prediction = PHT[pattern_out][1], read combinationally.
- fetch_ready = RUN && (count<DEPTH || commit_valid).
- Fetch accept: fetch = fetch_valid && fetch_ready && !(commit_valid && commit_failure). On fetch:
  - push {prediction, GHR} to the FIFO tail;
  - GHR <= {GHR[PAT_W-2:0], prediction}.
- Commit (commit_valid in RUN):
  - pop the FIFO head;
  - actual = head.prediction ^ commit_failure;
  - PHT[commit_pattern] counter saturates: +1 if actual, -1 if not, clamped to 0..3.
  - The PHT write lands at the clock edge.
- Same-index read/write in one cycle: the fetch read returns the pre-update value; there is no bypass.
- Misprediction (commit_valid && commit_failure):
  - GHR <= {head.GHR[PAT_W-2:0], actual};
  - FIFO count <= 0;
  - any simultaneous fetch_valid is dropped: no push, no GHR shift. The front end is being redirected that cycle.
- Commit without failure plus simultaneous fetch: count unchanged. Pop the head, push the tail.
- FIFO uses wrap-around head/tail pointers of $clog2(DEPTH) bits plus a count of $clog2(DEPTH)+1 bits.
- commit_valid with count==0 is illegal. Behaviour is undefined; the verification engineer flags it with an assertion.
- commit_pattern is trusted for the PHT update. Head GHR is used only for repair.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_commits[31:0] and stat_failures[31:0].
  - Both are saturating counters, cleared on reset.
  - stat_commits increments per commit; stat_failures increments per failing commit.
  - Both update in RUN only, and both outputs are registered.
- Undefined: the ports and logic are absent; other behaviour is identical.

Test Plan:
- Init: assert reset 1 cycle, PAT_W=4.
  - fetch_ready=0 for exactly 16 cycles, then 1.
  - First fetch at pc=0 -> prediction=0, pattern_out=0.
- Training: 2 commits at index 5, no failure, with head.prediction=0.
  - Counter goes 01->00. Then 2 commits with failure=1 -> counter 10.
  - A fetch hitting index 5 then predicts 1.
- History: GHR=0; fetch pc=3 (pred 0), then pc=3 again.
  - Second pattern_out=3, since GHR is still 0.
  - After forcing a pred-1 fetch, the next pattern_out = pc ^ 4'b0001.
- Full: 4 fetches without commit -> fetch_ready=0.
  - commit_valid with failure=0 plus fetch in the same cycle -> accepted, count stays 4.
- Recovery: 3 in flight, head GHR=4'b0110, head pred=1; commit failure=1 with fetch_valid=1.
  - GHR becomes 4'b1100, count=0, fetch dropped.
- Reset mid-RUN with 2 in flight: returns to INIT, GHR=0, count=0, all counters back to 01 after 16 cycles.
  - With BP_STATS_EN defined, the stats read 0.
